// File: rtl/alu_source_a_mux_pkg.sv
// Shared datapath constants: ALUSrcA encodings and the datapath word width.
// The control unit imports the same package so both sides agree on the encoding.
package alu_source_a_mux_pkg;

    localparam int DATAPATH_WIDTH = 16;

    localparam logic [1:0] SRCA_ZERO  = 2'd0;
    localparam logic [1:0] SRCA_ONE   = 2'd1;
    localparam logic [1:0] SRCA_TWO   = 2'd2;
    localparam logic [1:0] SRCA_THREE = 2'd3;

endpackage

// File: rtl/alu_source_a_mux_mux4.sv
// Combinational WIDTH-bit 4:1 select; the word passes through bit-exact.
module mux4
    import alu_source_a_mux_pkg::*;
#(
    parameter int WIDTH = DATAPATH_WIDTH
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            SRCA_ZERO:  y = d0;
            SRCA_ONE:   y = d1;
            SRCA_TWO:   y = d2;
            SRCA_THREE: y = d3;
            default:    y = d0;
        endcase
    end

endmodule

// File: rtl/alu_source_a_mux.sv
// Registered ALU A-operand select: mux4 followed by a reset-capable output register.
// No handshake: a new select and its data are captured on every rising CLK edge.
module alu_source_a_mux
    import alu_source_a_mux_pkg::*;
#(
    parameter int WIDTH = DATAPATH_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       ALUSrcA,
    input  logic [WIDTH-1:0] Zero,
    input  logic [WIDTH-1:0] One,
    input  logic [WIDTH-1:0] Two,
    input  logic [WIDTH-1:0] Three,
    output logic [WIDTH-1:0] Output,
    output logic [1:0]       SelQ
);

    logic [WIDTH-1:0] mux_y;

    mux4 #(
        .WIDTH(WIDTH)
    ) u_mux4 (
        .sel(ALUSrcA),
        .d0 (Zero),
        .d1 (One),
        .d2 (Two),
        .d3 (Three),
        .y  (mux_y)
    );

    // SelQ records which select produced the current Output, for trace.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Output <= '0;
            SelQ   <= SRCA_ZERO;
        end else begin
            Output <= mux_y;
            SelQ   <= ALUSrcA;
        end
    end

endmodule

// File: tb/tb_alu_source_a_mux.sv
// Bench for alu_source_a_mux: directed vector table, then random traffic against a source-array model.
module tb_alu_source_a_mux;

    localparam int W = 16;

    logic         CLK;
    logic         Reset;
    logic [1:0]   ALUSrcA;
    logic [W-1:0] Zero, One, Two, Three;
    logic [W-1:0] Output;
    logic [1:0]   SelQ;

    int checks = 0;
    int passes = 0;

    alu_source_a_mux #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .ALUSrcA(ALUSrcA),
        .Zero   (Zero),
        .One    (One),
        .Two    (Two),
        .Three  (Three),
        .Output (Output),
        .SelQ   (SelQ)
    );

    // clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic         rst;
        logic [1:0]   sel;
        logic [W-1:0] z, o, t, th;
        logic [W-1:0] exp_out;
        logic [1:0]   exp_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [1:0] sel, logic [W-1:0] z, logic [W-1:0] o,
                                logic [W-1:0] t, logic [W-1:0] th, logic [W-1:0] eo, logic [1:0] es);
        vec_t v;
        v.rst = rst; v.sel = sel; v.z = z; v.o = o; v.t = t; v.th = th;
        v.exp_out = eo; v.exp_sel = es;
        return v;
    endfunction

    // driver
    task automatic drive(input logic rst, input logic [1:0] sel, input logic [W-1:0] z,
                         input logic [W-1:0] o, input logic [W-1:0] t, input logic [W-1:0] th);
        Reset = rst; ALUSrcA = sel; Zero = z; One = o; Two = t; Three = th;
    endtask

    task automatic check(input string name, input int idx, input logic [W-1:0] exp_out,
                         input logic [1:0] exp_sel);
        checks++;
        if (Output === exp_out) passes++;
        else $display("FAIL %s[%0d] Output: got %h expected %h", name, idx, Output, exp_out);
        checks++;
        if (SelQ === exp_sel) passes++;
        else $display("FAIL %s[%0d] SelQ: got %0d expected %0d", name, idx, SelQ, exp_sel);
    endtask

    // reference model state: the four sources, indexed by select
    logic [W-1:0] src[4];
    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_sel_q[$];

    initial begin
        drive(1'b1, 2'd0, '0, '0, '0, '0);

        // directed table: each row is the input pairing sampled at one edge and what follows it
        vecs.push_back(mk(1, 0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0));
        vecs.push_back(mk(1, 3, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0001, 1));
        vecs.push_back(mk(0, 2, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0002, 2));
        vecs.push_back(mk(0, 3, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 3));
        vecs.push_back(mk(0, 3, 16'h1111, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'hFFFF, 3));
        vecs.push_back(mk(0, 0, 16'h1111, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h1111, 0));
        vecs.push_back(mk(0, 2, 16'h1111, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h5A5A, 2));
        vecs.push_back(mk(0, 1, 16'h1111, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'hA5A5, 1));
        // unselected isolation: only Two matters
        vecs.push_back(mk(0, 2, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 2));
        vecs.push_back(mk(0, 2, 16'hFFFF, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h1234, 2));
        vecs.push_back(mk(0, 2, 16'hAAAA, 16'h5555, 16'h1234, 16'h0F0F, 16'h1234, 2));
        vecs.push_back(mk(0, 2, 16'h0001, 16'h8000, 16'h1234, 16'hF0F0, 16'h1234, 2));
        // data follow with select held
        vecs.push_back(mk(0, 1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1));
        vecs.push_back(mk(0, 1, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 1));
        // mid-stream reset
        vecs.push_back(mk(0, 3, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 3));
        vecs.push_back(mk(1, 3, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0));
        vecs.push_back(mk(0, 3, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 3));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].sel, vecs[i].z, vecs[i].o, vecs[i].t, vecs[i].th);
            @(posedge CLK);
            #1;
            check("table", i, vecs[i].exp_out, vecs[i].exp_sel);
        end

        // random traffic; the last row above left Output=FFFF, SelQ=3
        exp_q.push_back(16'hFFFF);
        exp_sel_q.push_back(2'd3);
        for (int i = 0; i < 300; i++) begin
            logic       rst;
            logic [1:0] sel;
            rst = ($urandom_range(0, 15) == 0);
            sel = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) src[k] = W'($urandom);
            drive(rst, sel, src[0], src[1], src[2], src[3]);
            #1;
            // fresh inputs must not reach the outputs before the edge
            check("hold", i, exp_q[0], exp_sel_q[0]);
            void'(exp_q.pop_front());
            void'(exp_sel_q.pop_front());
            exp_q.push_back(rst ? '0 : src[sel]);
            exp_sel_q.push_back(rst ? 2'd0 : sel);
            @(posedge CLK);
            #1;
            check("rand", i, exp_q[0], exp_sel_q[0]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
